// File: rtl/ifetch_unit.sv
// ifetch_unit: single-outstanding instruction fetch with stall buffering and redirect handling.
// An abandoned request is tracked in DROP so its late response is never delivered.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000060
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_4,
    output logic        if_flush
);
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_BUF  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_drop_addr;
    logic [31:0] r_ibuf;
    logic [31:0] w_target;
    logic [31:0] w_pc_4;

    assign w_target = redirect_pc & 32'hFFFFFFFC;
    assign w_pc_4   = r_pc + 32'd4;

    always_comb begin
        imem_read    = ~rst & (r_state != S_BUF);
        imem_address = (r_state == S_DROP) ? r_drop_addr : r_pc;
        if_valid     = ~rst & ~redirect & ((r_state == S_REQ) ? imem_resp : (r_state == S_BUF));
        if_instr     = if_valid ? ((r_state == S_BUF) ? r_ibuf : imem_rdata) : NOP;
        if_pc        = r_pc;
        if_pc_4      = w_pc_4;
        if_flush     = redirect & ~rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_drop_addr <= 32'd0;
            r_ibuf      <= NOP;
        end else if (r_state == S_REQ) begin
            if (redirect) begin
                r_pc <= w_target;
                if (!imem_resp) begin
                    r_drop_addr <= r_pc;
                    r_state     <= S_DROP;
                end
            end else if (imem_resp) begin
                if (stall) begin
                    r_ibuf  <= imem_rdata;
                    r_state <= S_BUF;
                end else begin
                    r_pc <= w_pc_4;
                end
            end
        end else if (r_state == S_BUF) begin
            if (redirect) begin
                r_pc    <= w_target;
                r_state <= S_REQ;
            end else if (!stall) begin
                r_pc    <= w_pc_4;
                r_state <= S_REQ;
            end
        end else begin
            // The outstanding response belongs to the dropped request, so it only ends DROP.
            if (redirect) r_pc <= w_target;
            if (imem_resp) r_state <= S_REQ;
        end
    end
endmodule
